// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : Decode-to-execute pipeline register for the RV32I 5-stage core.
//            Captures the decoded control bundle and datapath fields, with
//            hazard-unit stall (hold) and flush (bubble) plus a valid bit.
//            Optional macro IDEX_PERF_EN adds bubble/stall perf counters;
//            when undefined, BubbleCnt and StallCnt are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [REGW-1:0] Rs1E,
  output logic [REGW-1:0] Rs2E,
  output logic [REGW-1:0] RdE,
  output logic [31:0]     BubbleCnt,
  output logic [31:0]     StallCnt
);

  logic            r_valid;
  logic            r_reg_write;
  logic [1:0]      r_result_src;
  logic            r_mem_write;
  logic            r_jump;
  logic            r_branch;
  logic [2:0]      r_alu_control;
  logic            r_alu_src;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_imm_ext;
  logic [REGW-1:0] r_rs1;
  logic [REGW-1:0] r_rs2;
  logic [REGW-1:0] r_rd;

  // Side-effect bits of a non-valid D instruction must never reach E.
  logic w_side_fx_ok;
  assign w_side_fx_ok = ValidD;

  // Pipeline register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushE) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_result_src  <= 2'b00;
      r_mem_write   <= 1'b0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_control <= 3'b000;
      r_alu_src     <= 1'b0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_pc          <= '0;
      r_pc_plus4    <= '0;
      r_imm_ext     <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
    end else if (!StallE) begin
      r_valid       <= ValidD;
      r_reg_write   <= RegWriteD & w_side_fx_ok;
      r_result_src  <= ResultSrcD;
      r_mem_write   <= MemWriteD & w_side_fx_ok;
      r_jump        <= JumpD & w_side_fx_ok;
      r_branch      <= BranchD & w_side_fx_ok;
      r_alu_control <= ALUControlD;
      r_alu_src     <= ALUSrcD;
      r_rd1         <= RD1D;
      r_rd2         <= RD2D;
      r_pc          <= PCD;
      r_pc_plus4    <= PCPlus4D;
      r_imm_ext     <= ImmExtD;
      r_rs1         <= Rs1D;
      r_rs2         <= Rs2D;
      r_rd          <= RdD;
    end
  end

  assign ValidE      = r_valid;
  assign RegWriteE   = r_reg_write;
  assign ResultSrcE  = r_result_src;
  assign MemWriteE   = r_mem_write;
  assign JumpE       = r_jump;
  assign BranchE     = r_branch;
  assign ALUControlE = r_alu_control;
  assign ALUSrcE     = r_alu_src;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign PCE         = r_pc;
  assign PCPlus4E    = r_pc_plus4;
  assign ImmExtE     = r_imm_ext;
  assign Rs1E        = r_rs1;
  assign Rs2E        = r_rs2;
  assign RdE         = r_rd;

`ifdef IDEX_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_bubble;
  logic        w_stall;

  // A bubble enters E on a flush, or on a load of a non-valid D slot.
  assign w_bubble = FlushE | (~StallE & ~ValidD);
  assign w_stall  = StallE & ~FlushE;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_stall)  r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign BubbleCnt = r_bubble_cnt;
  assign StallCnt  = r_stall_cnt;
`else
  assign BubbleCnt = 32'd0;
  assign StallCnt  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core; sits directly downstream of the main/ALU decoders and register file.
- Captures the decoded control bundle (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc) and the operand/immediate/PC datapath fields each cycle.
- Supports hazard-unit stall (hold) and flush (bubble insertion), and tracks a valid bit so downstream stages distinguish real instructions from bubbles.

Parameters:
XLEN, 32, datapath width of operands, immediate and PC fields
REGW, 5, register index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
StallE  input  1  hold all E-stage contents this cycle
FlushE  input  1  replace E-stage contents with a bubble this cycle
ValidD  input  1  D-stage holds a real instruction
RegWriteD  input  1  decoded register-write enable
ResultSrcD  input  2  decoded writeback select
MemWriteD  input  1  decoded store enable
JumpD  input  1  decoded jump
BranchD  input  1  decoded branch
ALUControlD  input  3  ALU operation
ALUSrcD  input  1  ALU B-operand select
RD1D, RD2D  input  XLEN  register-file read data
PCD, PCPlus4D, ImmExtD  input  XLEN  PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  input  REGW  source/destination indices
ValidE  output  1  E-stage holds a real instruction
RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE  output  (widths as D)  registered control
RD1E, RD2E, PCE, PCPlus4E, ImmExtE  output  XLEN  registered data
Rs1E, Rs2E, RdE  output  REGW  registered indices
BubbleCnt, StallCnt  output  32  performance counters (see Optional Feature)

Behaviour:
- Single clock domain clk; reset is asynchronous and active-high (port reset); asserting reset clears all state immediately, independent of clk.
- Reset value: every output 0 (ValidE=0, all control 0, all data 0, counters 0).
- Latency: one cycle; D inputs sampled at rising edge appear on E outputs after that edge.
- Priority per edge: reset > FlushE > StallE > load.
- Load (FlushE=0, StallE=0): all E registers <= D inputs; ValidE <= ValidD.
- Stall (StallE=1, FlushE=0): all E registers hold; D inputs ignored.
- Flush (FlushE=1, any StallE): bubble inserted: ValidE=0, RegWriteE=MemWriteE=JumpE=BranchE=0, ResultSrcE=0, ALUControlE=0, ALUSrcE=0, all data/index fields 0 (RdE=x0 so forwarding never matches).
- Bubble qualification: when ValidD=0 on a load, control side-effect bits (RegWriteE, MemWriteE, JumpE, BranchE) are forced 0 regardless of their D values; data fields still load.
- Consequence: side-effect bits are 1 only when ValidE=1.
- Reset mid-stall or mid-flush: reset wins, state clears immediately; first edge after deassertion performs a normal load/stall/flush.
- Pure registers, no combinational path from inputs to outputs.

Optional Feature:
- Macro IDEX_PERF_EN.
- Defined: BubbleCnt increments by 1 on each edge that inserts a bubble, i.e. FlushE=1, or a load with ValidD=0. StallCnt increments by 1 on each edge with StallE=1 and FlushE=0. Both wrap 0xFFFFFFFF -> 0 and clear on reset.
- Undefined: no counter logic; BubbleCnt and StallCnt are tied to 0.

Test Plan:
- Reset: assert reset between clock edges -> all outputs 0 immediately; release, load ValidD=1, RegWriteD=1, RdD=5, RD1D=0x1234 -> next edge ValidE=1, RegWriteE=1, RdE=5, RD1E=0x1234.
- Stall hold: load lw fields (ResultSrcD=01, ImmExtD=0x10). Then StallE=1 for 3 edges with changed D inputs -> E outputs unchanged. StallCnt=3 with IDEX_PERF_EN.
- Flush priority: StallE=1 and FlushE=1 together with MemWriteD=1 -> next edge ValidE=0, MemWriteE=0, RdE=0. BubbleCnt +1 with IDEX_PERF_EN.
- Invalid-D qualification: ValidD=0 with RegWriteD=1, BranchD=1, RD2D=0xABCD -> RegWriteE=0, BranchE=0, RD2E=0xABCD, ValidE=0.
- Back-to-back: loads on consecutive edges with PCD=0x0, 0x4, 0x8 -> PCE follows one cycle later each cycle, no dropped value.
- Counter wrap (IDEX_PERF_EN): force BubbleCnt to 0xFFFFFFFF, then one flush -> BubbleCnt=0; without the macro, counters read 0 throughout.
